trig_engine: RTL and testbench

TRIG_ENGINE -- requirements
Module: trig_engine

---
 rtl/trig_pkg.sv | 15 +
 rtl/trig_window_cmp.sv | 24 ++
 rtl/trig_engine.sv | 189 ++++++++++++++++++
 tb/tb_trig_engine.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/trig_pkg.sv
// Shared encodings for the trigger engine: capture modes and FSM states.
package trig_pkg;

  localparam logic [1:0] MODE_RISE   = 2'b00;
  localparam logic [1:0] MODE_FALL   = 2'b01;
  localparam logic [1:0] MODE_EITHER = 2'b10;
  localparam logic [1:0] MODE_OFF    = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_HOLDOFF = 2'd2
  } trig_state_t;

endpackage

// File: rtl/trig_window_cmp.sv
// Compares every tap of one window half against a threshold and AND-reduces.
// GE=1 checks tap >= thresh for all taps, GE=0 checks tap <= thresh.
module trig_window_cmp #(
  parameter int DATA_W = 8,
  parameter int N      = 5,
  parameter bit GE     = 1'b1
) (
  input  logic [N*DATA_W-1:0] taps,
  input  logic [DATA_W-1:0]   thresh,
  output logic                all_ok
);

  always_comb begin
    all_ok = 1'b1;
    for (int i = 0; i < N; i++) begin
      if (GE) begin
        if (taps[i*DATA_W +: DATA_W] < thresh) all_ok = 1'b0;
      end else begin
        if (taps[i*DATA_W +: DATA_W] > thresh) all_ok = 1'b0;
      end
    end
  end

endmodule

// File: rtl/trig_engine.sv
// Edge trigger over a two-half sample window with holdoff and single-shot.
// Optional hysteresis is enabled by defining TRIG_HYST_EN.
//
//   state      | meaning
//   -----------+-----------------------------------------------
//   ST_IDLE    | not looking for edges; waits for arm
//   ST_ARMED   | evaluating the window on every accepted sample
//   ST_HOLDOFF | edge seen; counting accepted samples to re-arm
module trig_engine
  import trig_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int HALF_WIN = 5,
  parameter int HOLD_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] din,
  input  logic              din_valid,
  input  logic [DATA_W-1:0] level,
  input  logic [DATA_W-1:0] hyst,
  input  logic [1:0]        mode,
  input  logic [HOLD_W-1:0] holdoff,
  input  logic              cfg_load,
  input  logic              arm,
  input  logic              disarm,
  input  logic              single,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  output logic              trig,
  output logic              armed
);

  localparam int TAPS   = 2 * HALF_WIN;
  localparam int FILL_W = $clog2(TAPS + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(TAPS);

  logic [DATA_W-1:0]          taps [TAPS];
  logic [HALF_WIN*DATA_W-1:0] new_bus, old_bus;
  logic [HALF_WIN-1:0]        pend;
  logic [HALF_WIN:0]          pend_nx;
  logic [FILL_W-1:0]          fill_cnt;
  logic                       filled;

  logic [DATA_W-1:0] level_q;
  logic [1:0]        mode_q;
  logic [HOLD_W-1:0] holdoff_q;
  logic [DATA_W-1:0] lo, hi;
  logic              hyst_zero;

  trig_state_t       state;
  logic [HOLD_W-1:0] hold_cnt;

  logic old_le_lo, new_ge_lvl, old_ge_hi, new_le_lvl;
  logic rise_hit, fall_hit, hit, det;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level_q   <= {1'b1, {(DATA_W-1){1'b0}}};
      mode_q    <= MODE_RISE;
      holdoff_q <= '0;
    end else if (cfg_load) begin
      level_q   <= level;
      mode_q    <= mode;
      holdoff_q <= holdoff;
    end
  end

`ifdef TRIG_HYST_EN
  logic [DATA_W-1:0] hyst_q;
  logic [DATA_W:0]   lo_ext, hi_ext;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)           hyst_q <= '0;
    else if (cfg_load) hyst_q <= hyst;
  end

  assign lo_ext    = {1'b0, level_q} - {1'b0, hyst_q};
  assign hi_ext    = {1'b0, level_q} + {1'b0, hyst_q};
  assign lo        = lo_ext[DATA_W] ? '0 : lo_ext[DATA_W-1:0];
  assign hi        = hi_ext[DATA_W] ? '1 : hi_ext[DATA_W-1:0];
  assign hyst_zero = (hyst_q == '0);
`else
  logic unused_hyst;
  assign unused_hyst = ^hyst;
  assign lo          = level_q;
  assign hi          = level_q;
  assign hyst_zero   = 1'b1;
`endif

  for (genvar i = 0; i < HALF_WIN; i++) begin : g_bus
    assign new_bus[i*DATA_W +: DATA_W] = taps[i];
    assign old_bus[i*DATA_W +: DATA_W] = taps[HALF_WIN+i];
  end

  trig_window_cmp #(.DATA_W(DATA_W), .N(HALF_WIN), .GE(1'b0)) u_old_le_lo (
    .taps(old_bus), .thresh(lo), .all_ok(old_le_lo));
  trig_window_cmp #(.DATA_W(DATA_W), .N(HALF_WIN), .GE(1'b1)) u_new_ge_lvl (
    .taps(new_bus), .thresh(level_q), .all_ok(new_ge_lvl));
  trig_window_cmp #(.DATA_W(DATA_W), .N(HALF_WIN), .GE(1'b1)) u_old_ge_hi (
    .taps(old_bus), .thresh(hi), .all_ok(old_ge_hi));
  trig_window_cmp #(.DATA_W(DATA_W), .N(HALF_WIN), .GE(1'b0)) u_new_le_lvl (
    .taps(new_bus), .thresh(level_q), .all_ok(new_le_lvl));

  assign rise_hit = old_le_lo & new_ge_lvl & (hyst_zero | (taps[TAPS-1] < lo));
  assign fall_hit = old_ge_hi & new_le_lvl & (hyst_zero | (taps[TAPS-1] > hi));

  always_comb begin
    case (mode_q)
      MODE_RISE:   hit = rise_hit;
      MODE_FALL:   hit = fall_hit;
      MODE_EITHER: hit = rise_hit | fall_hit;
      default:     hit = 1'b0;
    endcase
  end

  assign filled  = (fill_cnt == FILL_FULL);
  // disarm wins over a detection landing in the same cycle
  assign det     = din_valid & ~disarm & (state == ST_ARMED) & filled & hit;
  assign pend_nx = {pend, det};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < TAPS; i++) taps[i] <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      trig       <= 1'b0;
      pend       <= '0;
      fill_cnt   <= '0;
    end else begin
      dout_valid <= din_valid;
      trig       <= din_valid & pend[HALF_WIN-1];
      if (din_valid) begin
        taps[0] <= din;
        for (int i = 1; i < TAPS; i++) taps[i] <= taps[i-1];
        dout <= taps[TAPS-1];
        // pending bit travels in step with the crossing sample toward dout
        pend <= pend_nx[HALF_WIN-1:0];
        if (!filled) fill_cnt <= fill_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      hold_cnt <= '0;
      armed    <= 1'b0;
    end else if (disarm) begin
      state <= ST_IDLE;
      armed <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (arm) begin
            state <= ST_ARMED;
            armed <= 1'b1;
          end
        end
        ST_ARMED: begin
          if (det) begin
            armed <= 1'b0;
            if (single) begin
              state <= ST_IDLE;
            end else begin
              state    <= ST_HOLDOFF;
              hold_cnt <= holdoff_q;
            end
          end
        end
        ST_HOLDOFF: begin
          if (din_valid) begin
            if (hold_cnt == '0) begin
              state <= ST_ARMED;
              armed <= 1'b1;
            end else begin
              hold_cnt <= hold_cnt - 1'b1;
            end
          end
        end
        default: begin
          state <= ST_IDLE;
          armed <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_trig_engine.sv
// Bench for trig_engine: sample-history reference model checked every cycle,
// directed edge scenarios with literal expectations, then randomized traffic.
module tb_trig_engine;

  localparam int DW = 8;
  localparam int HW = 5;
  localparam int NT = 2 * HW;
`ifdef TRIG_HYST_EN
  localparam bit HYST_EN = 1'b1;
`else
  localparam bit HYST_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] din = '0;
  logic          din_valid = 1'b0;
  logic [DW-1:0] level = 8'h80;
  logic [DW-1:0] hyst = '0;
  logic [1:0]    mode = 2'b00;
  logic [15:0]   holdoff = '0;
  logic          cfg_load = 1'b0;
  logic          arm = 1'b0;
  logic          disarm = 1'b0;
  logic          single = 1'b0;
  logic [DW-1:0] dout;
  logic          dout_valid;
  logic          trig;
  logic          armed;

  trig_engine #(.DATA_W(DW), .HALF_WIN(HW), .HOLD_W(16)) dut (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
    .level(level), .hyst(hyst), .mode(mode), .holdoff(holdoff),
    .cfg_load(cfg_load), .arm(arm), .disarm(disarm), .single(single),
    .dout(dout), .dout_valid(dout_valid), .trig(trig), .armed(armed));

  always #5 clk = ~clk;

  // reference model: full history of accepted samples since reset
  int hist[$];
  int pend_q[$];
  int m_level, m_hyst, m_mode, m_holdoff, m_st, m_cnt;
  int e_dout, e_dv, e_trig, e_armed;
  int vectors = 0;
  int miscompares = 0;
  int trig_seen = 0;
  int last_trig_dout = 0;

  function automatic int samp(int idx);
    if (idx < 0 || idx >= hist.size()) return 0;
    return hist[idx];
  endfunction

  // window for sample k: old half = samples k-10..k-6, new half = k-5..k-1
  function automatic bit win_hit(int k);
    int h, lo, hi;
    bit r, f;
    if (k < NT) return 1'b0;
    h  = HYST_EN ? m_hyst : 0;
    lo = (m_level - h < 0) ? 0 : m_level - h;
    hi = (m_level + h > 255) ? 255 : m_level + h;
    r = 1'b1;
    f = 1'b1;
    for (int j = k - NT; j < k - HW; j++) begin
      if (samp(j) > lo) r = 1'b0;
      if (samp(j) < hi) f = 1'b0;
    end
    for (int j = k - HW; j < k; j++) begin
      if (samp(j) < m_level) r = 1'b0;
      if (samp(j) > m_level) f = 1'b0;
    end
    if (h != 0) begin
      if (!(samp(k - NT) < lo)) r = 1'b0;
      if (!(samp(k - NT) > hi)) f = 1'b0;
    end
    case (m_mode)
      0:       return r;
      1:       return f;
      2:       return r | f;
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_reset();
    hist.delete();
    pend_q.delete();
    m_level = 128; m_hyst = 0; m_mode = 0; m_holdoff = 0;
    m_st = 0; m_cnt = 0;
    e_dout = 0; e_dv = 0; e_trig = 0; e_armed = 0;
  endtask

  // m_st: 0 idle, 1 armed, 2 holdoff
  task automatic model_step();
    bit det;
    int k;
    det    = 1'b0;
    e_trig = 0;
    e_dv   = int'(din_valid);
    if (din_valid) begin
      k      = hist.size();
      det    = (m_st == 1) && !disarm && win_hit(k);
      e_dout = samp(k - NT);
      if (pend_q.size() > 0 && pend_q[0] == k) begin
        e_trig = 1;
        void'(pend_q.pop_front());
      end
      if (det) pend_q.push_back(k + HW);
      hist.push_back(int'(din));
    end
    if (disarm) m_st = 0;
    else if (m_st == 0) begin
      if (arm) m_st = 1;
    end else if (m_st == 1) begin
      if (det) begin
        if (single) m_st = 0;
        else begin
          m_st  = 2;
          m_cnt = m_holdoff;
        end
      end
    end else if (din_valid) begin
      if (m_cnt == 0) m_st = 1;
      else m_cnt = m_cnt - 1;
    end
    if (cfg_load) begin
      m_level = int'(level); m_hyst = int'(hyst);
      m_mode = int'(mode); m_holdoff = int'(holdoff);
    end
    e_armed = (m_st == 1) ? 1 : 0;
  endtask

  task automatic check(string name, int act, int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    if (!rst) model_step();
    @(negedge clk);
    check("dout", int'(dout), e_dout);
    check("dout_valid", int'(dout_valid), e_dv);
    check("trig", int'(trig), e_trig);
    check("armed", int'(armed), e_armed);
    if (trig) begin
      trig_seen++;
      last_trig_dout = int'(dout);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    #2;
    check("rst_dout", int'(dout), 0);
    check("rst_dout_valid", int'(dout_valid), 0);
    check("rst_trig", int'(trig), 0);
    check("rst_armed", int'(armed), 0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic send(int v, int gap);
    din = v[7:0];
    din_valid = 1'b1;
    cycle();
    din_valid = 1'b0;
    for (int g = 0; g < gap; g++) cycle();
  endtask

  task automatic ramp(int a, int na, int b, int nb, int gap);
    for (int i = 0; i < na; i++) send(a, gap);
    for (int i = 0; i < nb; i++) send(b, gap);
    for (int i = 0; i < 3; i++) cycle();
  endtask

  task automatic load_cfg(int lvl, int h, int md, int ho);
    level = lvl[7:0]; hyst = h[7:0]; mode = md[1:0]; holdoff = ho[15:0];
    cfg_load = 1'b1;
    cycle();
    cfg_load = 1'b0;
  endtask

  task automatic pulse_arm();
    arm = 1'b1;
    cycle();
    arm = 1'b0;
  endtask

  initial begin
    int t0, seg, hi_seg;
    model_reset();
    do_reset();

    // rising edge with default config
    load_cfg(8'h80, 0, 0, 0);
    pulse_arm();
    t0 = trig_seen;
    ramp(8'h10, 5, 8'h90, 12, 0);
    check("rise_count", trig_seen - t0, 1);
    check("rise_dout", last_trig_dout, 8'h90);

    // falling edge, then same stimulus with trigger disabled
    do_reset();
    load_cfg(8'h80, 0, 1, 0);
    pulse_arm();
    t0 = trig_seen;
    ramp(8'hF0, 5, 8'h20, 12, 0);
    check("fall_count", trig_seen - t0, 1);
    check("fall_dout", last_trig_dout, 8'h20);
    do_reset();
    load_cfg(8'h80, 0, 3, 0);
    pulse_arm();
    t0 = trig_seen;
    ramp(8'hF0, 5, 8'h20, 12, 0);
    check("off_count", trig_seen - t0, 0);

    // holdoff over a square wave
    do_reset();
    load_cfg(8'h80, 0, 0, 20);
    pulse_arm();
    for (int p = 0; p < 12; p++) begin
      for (int i = 0; i < 5; i++) send(8'h10, 0);
      for (int i = 0; i < 5; i++) send(8'h90, 0);
    end

`ifdef TRIG_HYST_EN
    do_reset();
    load_cfg(8'h80, 8'h10, 0, 0);
    pulse_arm();
    t0 = trig_seen;
    ramp(8'h78, 5, 8'h90, 12, 0);
    check("hyst_shallow_count", trig_seen - t0, 0);
    do_reset();
    load_cfg(8'h80, 8'h10, 0, 0);
    pulse_arm();
    t0 = trig_seen;
    ramp(8'h60, 5, 8'h90, 12, 0);
    check("hyst_deep_count", trig_seen - t0, 1);
    check("hyst_deep_dout", last_trig_dout, 8'h90);
`endif

    // single shot, then simultaneous arm/disarm
    do_reset();
    load_cfg(8'h80, 0, 0, 0);
    single = 1'b1;
    pulse_arm();
    t0 = trig_seen;
    ramp(8'h10, 5, 8'h90, 12, 0);
    check("single_count", trig_seen - t0, 1);
    check("single_armed", int'(armed), 0);
    arm = 1'b1;
    disarm = 1'b1;
    cycle();
    arm = 1'b0;
    disarm = 1'b0;
    cycle();
    check("arm_disarm_armed", int'(armed), 0);
    single = 1'b0;

    // gapped input keeps the same alignment
    do_reset();
    load_cfg(8'h80, 0, 0, 0);
    pulse_arm();
    t0 = trig_seen;
    ramp(8'h10, 5, 8'h90, 12, 2);
    check("gap_count", trig_seen - t0, 1);
    check("gap_dout", last_trig_dout, 8'h90);

    // reset while a trigger is in flight
    do_reset();
    load_cfg(8'h80, 0, 0, 0);
    pulse_arm();
    ramp(8'h10, 5, 8'h90, 7, 0);
    do_reset();
    pulse_arm();
    t0 = trig_seen;
    for (int i = 0; i < 12; i++) send(8'h90, 0);
    check("rst_inflight_count", trig_seen - t0, 0);

    // randomized traffic
    do_reset();
    load_cfg(8'h80, 8'h08, 0, 4);
    pulse_arm();
    seg = 5;
    hi_seg = 0;
    for (int c = 0; c < 3000; c++) begin
      if (seg == 0) begin
        hi_seg = 1 - hi_seg;
        seg = int'($urandom_range(3, 8));
      end
      din = hi_seg != 0 ? 8'($urandom_range(8'hB0, 8'hFF)) : 8'($urandom_range(0, 8'h50));
      din_valid = ($urandom_range(0, 3) != 0);
      if (din_valid) seg--;
      cfg_load = ($urandom_range(0, 99) < 2);
      if (cfg_load) begin
        level   = 8'($urandom_range(8'h60, 8'hA0));
        hyst    = 8'($urandom_range(0, 8'h30));
        mode    = 2'($urandom_range(0, 3));
        holdoff = 16'($urandom_range(0, 30));
        single  = ($urandom_range(0, 3) == 0);
      end
      arm    = ($urandom_range(0, 99) < 5);
      disarm = ($urandom_range(0, 99) < 1);
      cycle();
    end
    din_valid = 1'b0; cfg_load = 1'b0; arm = 1'b0; disarm = 1'b0;
    cycle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
